// File: rtl/cic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cic_pkg
// Brief    : Shared types and constants for the CIC decimation controller.
// Revision : 1.0 - initial release
// ============================================================================
package cic_pkg;

    localparam int c_DATA_W_DEF = 16;
    localparam int c_DEC_W_DEF  = 8;

    localparam logic [1:0] c_ADDR_CTRL  = 2'd0;
    localparam logic [1:0] c_ADDR_DECIM = 2'd1;
    localparam logic [1:0] c_ADDR_SHIFT = 2'd2;

    localparam int c_CTRL_EN_BIT  = 0;
    localparam int c_CTRL_CLR_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cic_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cic_sequencer_if
// Brief    : Config, datapath and output-stream signals of the CIC controller.
// Revision : 1.0 - initial release
// ============================================================================
interface cic_sequencer_if #(
    parameter int DATA_W = cic_pkg::c_DATA_W_DEF
);
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [7:0]        cfg_wdata;
    logic              dp_clear;
    logic              dp_strobe;
    logic              in_valid;
    logic [DATA_W-1:0] in_sample;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              overrun;
    logic [7:0]        ovr_count;

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_sample, out_ready,
        output dp_clear, dp_strobe, out_valid, out_data, busy, overrun, ovr_count
    );

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, in_valid, in_sample, out_ready,
        input  dp_clear, dp_strobe, out_valid, out_data, busy, overrun, ovr_count
    );
endinterface
`default_nettype wire

// File: rtl/cic_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cic_out_fifo
// Brief    : 2-entry output FIFO with synchronous clear; caller guards push/pop.
// Revision : 1.0 - initial release
// ============================================================================
module cic_out_fifo #(
    parameter int DATA_W = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              clr,
    input  wire logic              push,
    input  wire logic              pop,
    input  wire logic [DATA_W-1:0] din,
    output logic      [DATA_W-1:0] dout,
    output logic                   full,
    output logic                   empty
);
    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (clr) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) r_wr_ptr <= ~r_wr_ptr;
            if (pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push && !clr) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == 2'd2);
    assign empty = (r_count == 2'd0);
endmodule
`default_nettype wire

// File: rtl/cic_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cic_sequencer
// Brief    : CIC decimator controller: config regs, strobe/clear, warm-up
//            discard and 2-deep output buffering on a valid/ready port.
// Options  : CIC_OVR_CNT_EN - enables the saturating dropped-sample counter.
// Revision : 1.0 - initial release
// ============================================================================
module cic_sequencer
    import cic_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int DEC_W  = c_DEC_W_DEF,
    parameter int WARMUP = 2
) (
    input wire logic        clk,
    input wire logic        reset,
    cic_sequencer_if.slave  bus
);
    localparam int c_WARM_W = $clog2(WARMUP + 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [DEC_W-1:0]          r_decim;
    logic [DEC_W-1:0]          r_strb_cnt;
    logic [3:0]                r_shift;
    logic [c_WARM_W-1:0]       r_warm_cnt;
    logic                      r_overrun;

    logic w_ctrl_wr, w_decim_wr, w_shift_wr;
    logic w_en_on, w_en_off, w_restart;
    logic w_active, w_clr, w_dp_clear, w_busy;
    logic w_push, w_pop, w_drop;
    logic w_fifo_full, w_fifo_empty;
    logic        [DATA_W-1:0]  w_head;
    logic signed [DATA_W-1:0]  w_shifted;

    assign w_ctrl_wr  = bus.cfg_we && (bus.cfg_addr == c_ADDR_CTRL);
    assign w_decim_wr = bus.cfg_we && (bus.cfg_addr == c_ADDR_DECIM);
    assign w_shift_wr = bus.cfg_we && (bus.cfg_addr == c_ADDR_SHIFT);
    assign w_en_on    = w_ctrl_wr &&  bus.cfg_wdata[c_CTRL_EN_BIT];
    assign w_en_off   = w_ctrl_wr && !bus.cfg_wdata[c_CTRL_EN_BIT];
    assign w_restart  = (w_en_on && bus.cfg_wdata[c_CTRL_CLR_BIT]) || w_decim_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_active    = 1'b0;
        w_dp_clear  = 1'b1;
        w_busy      = (r_state != ST_IDLE);
        if (w_en_off) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_en_on) w_state_nxt = ST_FLUSH;
                ST_FLUSH:  w_state_nxt = ST_WARMUP;
                ST_WARMUP: begin
                    if (w_restart)
                        w_state_nxt = ST_FLUSH;
                    else if (bus.in_valid && (r_warm_cnt == c_WARM_W'(WARMUP - 1)))
                        w_state_nxt = ST_RUN;
                end
                ST_RUN:    if (w_restart) w_state_nxt = ST_FLUSH;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
        if (r_state == ST_WARMUP || r_state == ST_RUN) begin
            w_active   = 1'b1;
            w_dp_clear = 1'b0;
        end
    end

    // Everything downstream restarts whenever the FSM is headed for FLUSH or IDLE.
    assign w_clr = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FLUSH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_decim <= '0;
            r_shift <= 4'd0;
        end else begin
            if (w_decim_wr) r_decim <= DEC_W'(bus.cfg_wdata);
            if (w_shift_wr) r_shift <= bus.cfg_wdata[3:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_strb_cnt <= '0;
            r_warm_cnt <= '0;
        end else if (w_clr) begin
            r_strb_cnt <= '0;
            r_warm_cnt <= '0;
        end else begin
            if (w_active)
                r_strb_cnt <= (r_strb_cnt == r_decim) ? '0 : r_strb_cnt + 1'b1;
            if (r_state == ST_WARMUP && bus.in_valid)
                r_warm_cnt <= r_warm_cnt + 1'b1;
        end
    end

    assign w_pop  = !w_fifo_empty && bus.out_ready;
    assign w_push = (r_state == ST_RUN) && bus.in_valid && (!w_fifo_full || w_pop);
    assign w_drop = (r_state == ST_RUN) && bus.in_valid && w_fifo_full && !w_pop;

    cic_out_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.in_sample),
        .dout  (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_overrun <= 1'b0;
        else if (w_clr)  r_overrun <= 1'b0;
        else if (w_drop) r_overrun <= 1'b1;
    end

`ifdef CIC_OVR_CNT_EN
    logic [7:0] r_ovr_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            r_ovr_cnt <= 8'd0;
        else if (w_clr)                       r_ovr_cnt <= 8'd0;
        else if (w_drop && r_ovr_cnt != 8'hFF) r_ovr_cnt <= r_ovr_cnt + 8'd1;
    end
    assign bus.ovr_count = r_ovr_cnt;
`else
    assign bus.ovr_count = 8'd0;
`endif

    assign w_shifted     = $signed(w_head) >>> r_shift;
    assign bus.out_valid = !w_fifo_empty;
    assign bus.out_data  = w_fifo_empty ? '0 : w_shifted;
    assign bus.dp_clear  = w_dp_clear;
    assign bus.dp_strobe = w_active && (r_strb_cnt == r_decim);
    assign bus.busy      = w_busy;
    assign bus.overrun   = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_cic_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cic_sequencer
// Brief    : Directed, table-driven bench for cic_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cic_sequencer;
    import cic_pkg::*;

`ifdef CIC_OVR_CNT_EN
    localparam logic [7:0] c_E1   = 8'd1;
    localparam logic [7:0] c_ESAT = 8'd255;
`else
    localparam logic [7:0] c_E1   = 8'd0;
    localparam logic [7:0] c_ESAT = 8'd0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cic_sequencer_if #(.DATA_W(16)) bus();

    cic_sequencer #(.DATA_W(16), .DEC_W(8), .WARMUP(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [7:0]  wdata;
        logic        iv;
        logic [15:0] samp;
        logic        rdy;
        logic        e_clr;
        logic        e_stb;
        logic        e_ov;
        logic [15:0] e_data;
        logic        e_busy;
        logic        e_ovr;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(input logic we, input logic [1:0] addr, input logic [7:0] wdata,
                                input logic iv, input logic [15:0] samp, input logic rdy,
                                input logic e_clr, input logic e_stb, input logic e_ov,
                                input logic [15:0] e_data, input logic e_busy,
                                input logic e_ovr, input logic [7:0] e_cnt);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.iv = iv; v.samp = samp; v.rdy = rdy;
        v.e_clr = e_clr; v.e_stb = e_stb; v.e_ov = e_ov; v.e_data = e_data;
        v.e_busy = e_busy; v.e_ovr = e_ovr; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic we, input logic [1:0] addr, input logic [7:0] wdata,
                         input logic iv, input logic [15:0] samp, input logic rdy);
        bus.cfg_we    = we;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = wdata;
        bus.in_valid  = iv;
        bus.in_sample = samp;
        bus.out_ready = rdy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input int idx, input vec_t v);
        logic [12:0] act_f, exp_f;
        logic        data_ok;
        act_f = {bus.dp_clear, bus.dp_strobe, bus.out_valid, bus.busy, bus.overrun, bus.ovr_count};
        exp_f = {v.e_clr, v.e_stb, v.e_ov, v.e_busy, v.e_ovr, v.e_cnt};
        data_ok = !v.e_ov || (bus.out_data === v.e_data);
        n_tests++;
        if (act_f !== exp_f || !data_ok) begin
            n_fail++;
            $display("FAIL vec%0d: got clr/stb/ov/busy/ovr/cnt=%b data=0x%04h expected %b data=0x%04h",
                     idx, act_f, bus.out_data, exp_f, v.e_data);
        end
    endtask

    initial begin
        //   we a  wdata iv samp    rdy | clr stb ov data     busy ovr cnt
        add(0, 0, 8'd0, 0, 16'd0,   0,   1, 0, 0, 16'd0,   0, 0, 8'd0);  // 0 idle after reset
        add(1, 1, 8'd3, 0, 16'd0,   0,   1, 0, 0, 16'd0,   0, 0, 8'd0);  // 1 DECIM=3
        add(1, 0, 8'd1, 0, 16'd0,   0,   1, 0, 0, 16'd0,   1, 0, 8'd0);  // 2 enable -> FLUSH
        add(0, 0, 8'd0, 0, 16'd0,   0,   0, 0, 0, 16'd0,   1, 0, 8'd0);  // 3 WARMUP cnt0
        add(0, 0, 8'd0, 0, 16'd0,   0,   0, 0, 0, 16'd0,   1, 0, 8'd0);
        add(0, 0, 8'd0, 0, 16'd0,   0,   0, 0, 0, 16'd0,   1, 0, 8'd0);
        add(0, 0, 8'd0, 0, 16'd0,   0,   0, 1, 0, 16'd0,   1, 0, 8'd0);  // 6 first strobe
        add(0, 0, 8'd0, 1, 16'd10,  0,   0, 0, 0, 16'd0,   1, 0, 8'd0);  // 7 discard 10
        add(0, 0, 8'd0, 1, 16'd20,  0,   0, 0, 0, 16'd0,   1, 0, 8'd0);  // 8 discard 20
        add(0, 0, 8'd0, 1, 16'd30,  0,   0, 0, 1, 16'd30,  1, 0, 8'd0);  // 9 push 30
        add(0, 0, 8'd0, 1, 16'd40,  1,   0, 1, 1, 16'd40,  1, 0, 8'd0);  // 10 pop 30 push 40
        add(0, 0, 8'd0, 0, 16'd0,   1,   0, 0, 0, 16'd0,   1, 0, 8'd0);  // 11 drained
        add(1, 2, 8'd2, 1, 16'hFFF8,0,   0, 0, 1, 16'hFFFE,1, 0, 8'd0);  // 12 SHIFT=2, -8 -> -2
        add(0, 0, 8'd0, 0, 16'd0,   1,   0, 0, 0, 16'd0,   1, 0, 8'd0);
        add(1, 2, 8'd0, 0, 16'd0,   0,   0, 1, 0, 16'd0,   1, 0, 8'd0);  // 14 SHIFT=0
        add(0, 0, 8'd0, 1, 16'd100, 0,   0, 0, 1, 16'd100, 1, 0, 8'd0);
        add(0, 0, 8'd0, 1, 16'd200, 0,   0, 0, 1, 16'd100, 1, 0, 8'd0);  // 16 full
        add(0, 0, 8'd0, 1, 16'd300, 0,   0, 0, 1, 16'd100, 1, 1, c_E1);  // 17 dropped
        add(0, 0, 8'd0, 1, 16'd400, 1,   0, 1, 1, 16'd200, 1, 1, c_E1);  // 18 push+pop while full
        add(0, 0, 8'd0, 0, 16'd0,   1,   0, 0, 1, 16'd400, 1, 1, c_E1);
        add(0, 0, 8'd0, 0, 16'd0,   0,   0, 0, 1, 16'd400, 1, 1, c_E1);  // 20 held stable
        add(1, 1, 8'd0, 0, 16'd0,   0,   1, 0, 0, 16'd0,   1, 0, 8'd0);  // 21 DECIM write -> FLUSH
        add(0, 0, 8'd0, 0, 16'd0,   0,   0, 1, 0, 16'd0,   1, 0, 8'd0);  // 22 DECIM=0 strobe
        add(0, 0, 8'd0, 1, 16'd5,   0,   0, 1, 0, 16'd0,   1, 0, 8'd0);
        add(0, 0, 8'd0, 1, 16'd6,   0,   0, 1, 0, 16'd0,   1, 0, 8'd0);
        add(0, 0, 8'd0, 1, 16'd7,   0,   0, 1, 1, 16'd7,   1, 0, 8'd0);  // 25 warm-up repeated
        add(1, 0, 8'd0, 0, 16'd0,   0,   1, 0, 0, 16'd0,   0, 0, 8'd0);  // 26 disable -> IDLE
        add(1, 0, 8'd1, 1, 16'd99,  0,   1, 0, 0, 16'd0,   1, 0, 8'd0);  // 27 enable, iv ignored
        add(0, 0, 8'd0, 0, 16'd0,   0,   0, 1, 0, 16'd0,   1, 0, 8'd0);
        add(0, 0, 8'd0, 1, 16'd1,   0,   0, 1, 0, 16'd0,   1, 0, 8'd0);
        add(0, 0, 8'd0, 1, 16'd2,   0,   0, 1, 0, 16'd0,   1, 0, 8'd0);
        add(0, 0, 8'd0, 1, 16'd3,   0,   0, 1, 1, 16'd3,   1, 0, 8'd0);
        add(1, 0, 8'd3, 0, 16'd0,   0,   1, 0, 0, 16'd0,   1, 0, 8'd0);  // 32 CTRL clear -> FLUSH
        add(0, 0, 8'd0, 0, 16'd0,   0,   0, 1, 0, 16'd0,   1, 0, 8'd0);
        add(1, 3, 8'd0, 0, 16'd0,   0,   0, 1, 0, 16'd0,   1, 0, 8'd0);  // 34 reserved addr ignored

        reset = 1'b1;
        drive(0, 0, 8'd0, 0, 16'd0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset dp_clear",  32'(bus.dp_clear),  32'd1);
        chk("reset dp_strobe", 32'(bus.dp_strobe), 32'd0);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out_data",  32'(bus.out_data),  32'd0);
        chk("reset busy",      32'(bus.busy),      32'd0);
        chk("reset overrun",   32'(bus.overrun),   32'd0);
        chk("reset ovr_count", 32'(bus.ovr_count), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].iv, vecs[i].samp, vecs[i].rdy);
            tick();
            chk_vec(i, vecs[i]);
        end

        // Asynchronous reset in RUN with a sample buffered.
        drive(0, 0, 8'd0, 1, 16'd1, 0);      tick();
        drive(0, 0, 8'd0, 1, 16'd2, 0);      tick();
        drive(0, 0, 8'd0, 1, 16'h1234, 0);   tick();
        chk("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
        chk("pre-reset out_data",  32'(bus.out_data),  32'h1234);
        drive(0, 0, 8'd0, 0, 16'd0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset dp_clear",  32'(bus.dp_clear),  32'd1);
        chk("async reset busy",      32'(bus.busy),      32'd0);
        chk("async reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("async reset dp_strobe", 32'(bus.dp_strobe), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // DECIM resets to 0; then saturate the drop counter with ready held low.
        drive(1, 0, 8'd1, 0, 16'd0, 0);      tick();
        drive(0, 0, 8'd0, 0, 16'd0, 0);      tick();
        chk("post-reset DECIM=0 strobe", 32'(bus.dp_strobe), 32'd1);
        drive(0, 0, 8'd0, 1, 16'hAAAA, 0);   tick();
        drive(0, 0, 8'd0, 1, 16'hBBBB, 0);   tick();
        chk("warm-up discards", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 260; i++) begin
            drive(0, 0, 8'd0, 1, 16'(i + 1), 0);
            tick();
        end
        chk("sat overrun",   32'(bus.overrun),   32'd1);
        chk("sat ovr_count", 32'(bus.ovr_count), 32'(c_ESAT));
        chk("sat head",      32'(bus.out_data),  32'd1);
        drive(0, 0, 8'd0, 0, 16'd0, 1);      tick();
        chk("sat second entry", 32'(bus.out_data), 32'd2);
        drive(0, 0, 8'd0, 0, 16'd0, 0);      tick();
        chk("sat second held",  32'(bus.out_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
